// File: rtl/btb_pkg.sv
// Shared types and helpers for the tagged 2-bit branch target buffer.
// Counter encoding, allocation state and saturating counter step.
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  localparam cnt_e ALLOC_STATE = WT;

  function automatic cnt_e sat_next(
    input cnt_e c,
    input logic taken
  );
    cnt_e n;
    n = c;
    unique case (1'b1)
      taken && (c != ST):   n = cnt_e'(c + 2'd1);
      !taken && (c != SNT): n = cnt_e'(c - 2'd1);
      default:              n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btb_2bit_predictor.sv
// Direct-mapped tagged BTB with 2-bit hysteresis counters.
// Combinational IF lookup, EX writeback, flush and perf counters.
module btb_2bit_predictor
  import btb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_lookup_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_mispredict,
  input  logic              i_flush,
  output logic [31:0]       o_upd_cnt,
  output logic [31:0]       o_mispred_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int N     = 1 << INDEX_W;

  logic [N-1:0]      r_valid;
  logic [TAG_W-1:0]  r_tag [N];
  logic [ADDR_W-1:0] r_tgt [N];
  cnt_e              r_cnt [N];
  logic [31:0]       r_upd_cnt;
  logic [31:0]       r_mis_cnt;

  logic [INDEX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  cnt_e               w_lk_cnt;
  logic               w_lk_hit;

  logic [INDEX_W-1:0] w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_up_act;
  logic               w_do_hit;
  logic               w_do_alloc;
  logic               w_unused_bits;

  assign w_unused_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_idx = i_lookup_pc[INDEX_W+1:2];
  assign w_lk_tag = i_lookup_pc[ADDR_W-1:INDEX_W+2];
  assign w_lk_cnt = r_cnt[w_lk_idx];
  assign w_lk_hit = r_valid[w_lk_idx]
                  && (r_tag[w_lk_idx] == w_lk_tag);

  assign o_pred_hit    = w_lk_hit;
  assign o_pred_taken  = w_lk_hit && w_lk_cnt[1];
  assign o_pred_target = o_pred_taken
                       ? r_tgt[w_lk_idx]
                       : i_lookup_pc + ADDR_W'(4);

  assign w_up_idx = i_upd_pc[INDEX_W+1:2];
  assign w_up_tag = i_upd_pc[ADDR_W-1:INDEX_W+2];
  assign w_up_hit = r_valid[w_up_idx]
                  && (r_tag[w_up_idx] == w_up_tag);

  // Flush wins over any entry write; only taken misses evict.
  assign w_up_act   = i_upd_valid && !i_flush;
  assign w_do_hit   = w_up_act && w_up_hit;
  assign w_do_alloc = w_up_act && !w_up_hit && i_upd_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      unique case (1'b1)
        i_flush: begin
          r_valid <= '0;
        end
        w_do_alloc: begin
          r_valid[w_up_idx] <= 1'b1;
          r_tag[w_up_idx]   <= w_up_tag;
          r_tgt[w_up_idx]   <= i_upd_target;
          r_cnt[w_up_idx]   <= ALLOC_STATE;
        end
        w_do_hit: begin
          r_cnt[w_up_idx] <= sat_next(r_cnt[w_up_idx],
                                      i_upd_taken);
          if (i_upd_taken)
            r_tgt[w_up_idx] <= i_upd_target;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (i_upd_valid) begin
      r_upd_cnt <= r_upd_cnt + 32'd1;
      if (i_upd_mispredict)
        r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign o_upd_cnt     = r_upd_cnt;
  assign o_mispred_cnt = r_mis_cnt;

endmodule

// File: tb/tb_btb_2bit_predictor.sv
// Self-checking bench: associative-array reference model compared
// every cycle, plus directed literal checks.
module tb_btb_2bit_predictor;

  localparam int IW = 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_lookup_pc;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_mispredict;
  logic        i_flush;
  logic [31:0] o_upd_cnt;
  logic [31:0] o_mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 0;

  btb_2bit_predictor #(.ADDR_W(32), .INDEX_W(IW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_lookup_pc      (i_lookup_pc),
    .o_pred_hit       (o_pred_hit),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .i_upd_valid      (i_upd_valid),
    .i_upd_pc         (i_upd_pc),
    .i_upd_taken      (i_upd_taken),
    .i_upd_target     (i_upd_target),
    .i_upd_mispredict (i_upd_mispredict),
    .i_flush          (i_flush),
    .o_upd_cnt        (o_upd_cnt),
    .o_mispred_cnt    (o_mispred_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: an entry exists only while valid.
  int unsigned m_ctr [int];
  logic [31:0] m_tag [int];
  logic [31:0] m_tgt [int];
  logic [31:0] m_upd;
  logic [31:0] m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % (1 << IW));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 << IW);
  endfunction

  function automatic void model_look(
    input  logic [31:0] pc,
    output logic        h,
    output logic        t,
    output logic [31:0] tg
  );
    int k;
    k  = idx_of(pc);
    h  = m_ctr.exists(k) && (m_tag[k] == tag_of(pc));
    t  = h && (m_ctr[k] >= 2);
    tg = t ? m_tgt[k] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int k;
    logic h;
    if (!rst_n) begin
      m_ctr.delete();
      m_tag.delete();
      m_tgt.delete();
      m_upd = 0;
      m_mis = 0;
    end else if (i_upd_valid) begin
      m_upd = m_upd + 1;
      if (i_upd_mispredict) m_mis = m_mis + 1;
      k = idx_of(i_upd_pc);
      h = m_ctr.exists(k) && (m_tag[k] == tag_of(i_upd_pc));
      if (i_flush) begin
        m_ctr.delete();
        m_tag.delete();
        m_tgt.delete();
      end else if (h) begin
        if (i_upd_taken) begin
          m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
          m_tgt[k] = i_upd_target;
        end else begin
          m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
        end
      end else if (i_upd_taken) begin
        m_ctr[k] = 2;
        m_tag[k] = tag_of(i_upd_pc);
        m_tgt[k] = i_upd_target;
      end
    end else if (i_flush) begin
      m_ctr.delete();
      m_tag.delete();
      m_tgt.delete();
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", nm, got, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    logic        h, t;
    logic [31:0] tg;
    if (!done) begin
      model_look(i_lookup_pc, h, t, tg);
      chk("cyc_hit", 32'(o_pred_hit), 32'(h));
      chk("cyc_taken", 32'(o_pred_taken), 32'(t));
      chk("cyc_target", o_pred_target, tg);
      chk("cyc_updcnt", o_upd_cnt, m_upd);
      chk("cyc_miscnt", o_mispred_cnt, m_mis);
    end
  end

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic mis,
                     input logic fl);
    i_upd_valid      = 1;
    i_upd_pc         = pc;
    i_upd_taken      = tk;
    i_upd_target     = tg;
    i_upd_mispredict = mis;
    i_flush          = fl;
    @(posedge clk);
    #1;
    i_upd_valid      = 0;
    i_upd_mispredict = 0;
    i_flush          = 0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc,
                      input logic h, input logic t,
                      input logic [31:0] tg);
    i_lookup_pc = pc;
    #1;
    chk({nm, "_hit"}, 32'(o_pred_hit), 32'(h));
    chk({nm, "_taken"}, 32'(o_pred_taken), 32'(t));
    chk({nm, "_tgt"}, o_pred_target, tg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 0;
    i_lookup_pc      = 32'h100;
    i_upd_valid      = 0;
    i_upd_pc         = 0;
    i_upd_taken      = 0;
    i_upd_target     = 0;
    i_upd_mispredict = 0;
    i_flush          = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;

    look("rst", 32'h100, 0, 0, 32'h104);
    chk("rst_updcnt", o_upd_cnt, 32'd0);
    chk("rst_miscnt", o_mispred_cnt, 32'd0);

    i_lookup_pc = 32'h100;
    i_upd_valid = 1;
    i_upd_pc = 32'h100;
    i_upd_taken = 1;
    i_upd_target = 32'h200;
    #1;
    chk("same_cyc_hit", 32'(o_pred_hit), 32'd0);
    @(posedge clk);
    #1;
    i_upd_valid = 0;
    look("alloc", 32'h100, 1, 1, 32'h200);

    upd(32'h100, 0, 32'h0, 0, 0);
    look("wnt", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 1, 32'h200, 0, 0);
    upd(32'h100, 1, 32'h200, 0, 0);
    look("st", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 0, 0);
    look("st_wt", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 0, 0);
    look("wt_wnt", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 0, 32'h0, 0, 0);
    upd(32'h100, 0, 32'h0, 0, 0);
    look("snt", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 1, 32'h240, 0, 0);
    look("snt_sat", 32'h100, 1, 0, 32'h104);

    upd(32'h100, 1, 32'h200, 0, 0);
    look("retk", 32'h100, 1, 1, 32'h200);
    upd(32'h1100, 0, 32'h0, 0, 0);
    look("alias_nt", 32'h100, 1, 1, 32'h200);
    upd(32'h1100, 1, 32'h300, 0, 0);
    look("alias_old", 32'h100, 0, 0, 32'h104);
    look("alias_new", 32'h1100, 1, 1, 32'h300);
    chk("pre_flush_cnt", o_upd_cnt, 32'd12);

    i_lookup_pc = 32'h1100;
    i_upd_valid = 1;
    i_upd_pc = 32'h400;
    i_upd_taken = 1;
    i_upd_target = 32'h480;
    i_flush = 1;
    #1;
    chk("flush_cyc_hit", 32'(o_pred_hit), 32'd1);
    @(posedge clk);
    #1;
    i_upd_valid = 0;
    i_flush = 0;
    look("fl_400", 32'h400, 0, 0, 32'h404);
    look("fl_1100", 32'h1100, 0, 0, 32'h1104);
    chk("flush_cnt", o_upd_cnt, 32'd13);

    force dut.r_mis_cnt = 32'hFFFF_FFFF;
    m_mis = 32'hFFFF_FFFF;
    #1;
    release dut.r_mis_cnt;
    chk("mis_preload", o_mispred_cnt, 32'hFFFF_FFFF);
    upd(32'h500, 0, 32'h0, 1, 0);
    chk("mis_wrap", o_mispred_cnt, 32'd0);
    chk("wrap_updcnt", o_upd_cnt, 32'd14);

    upd(32'h1100, 1, 32'h300, 0, 0);
    look("realloc", 32'h1100, 1, 1, 32'h300);
    i_upd_valid = 1;
    i_upd_pc = 32'h2200;
    i_upd_taken = 1;
    i_upd_target = 32'h700;
    rst_n = 0;
    #1;
    chk("arst_hit", 32'(o_pred_hit), 32'd0);
    chk("arst_taken", 32'(o_pred_taken), 32'd0);
    chk("arst_tgt", o_pred_target, 32'h1104);
    chk("arst_upd", o_upd_cnt, 32'd0);
    @(posedge clk);
    #1;
    i_upd_valid = 0;
    rst_n = 1;
    look("post_rst", 32'h2200, 0, 0, 32'h2204);
    chk("post_rst_cnt", o_upd_cnt, 32'd0);
    @(posedge clk);
    #1;
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_2bit_predictor.md
# btb_2bit_predictor

Parametrised, tagged, direct-mapped branch target buffer with per-entry 2-bit saturating direction counters, replacing the untagged 1-bit-predict RAM BTB in the pipelined forwarding core. The IF stage presents the fetch PC and receives a same-cycle next-PC prediction. The EX stage writes back resolved branch outcomes. Adds tag check, valid bits, hysteresis, allocate-on-taken, synchronous flush and performance counters.

## Interface
Parameters:
- ADDR_W, 32, PC width.
- INDEX_W, 6, log2 of entry count (default 64 entries).
- TAG_W, ADDR_W-INDEX_W-2, tag width (derived localparam, not overridable).

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_lookup_pc  in  ADDR_W  IF-stage fetch PC.
- o_pred_hit  out  1  valid entry with matching tag at lookup index.
- o_pred_taken  out  1  o_pred_hit and counter MSB set.
- o_pred_target  out  ADDR_W  stored target if o_pred_taken, else i_lookup_pc+4.
- i_upd_valid  in  1  EX stage resolved a branch/jump this cycle.
- i_upd_pc  in  ADDR_W  PC of the resolved instruction.
- i_upd_taken  in  1  actual direction.
- i_upd_target  in  ADDR_W  actual target (meaningful when taken).
- i_upd_mispredict  in  1  EX detected wrong prediction (only counted).
- i_flush  in  1  invalidate all entries.
- o_upd_cnt  out  32  number of accepted updates.
- o_mispred_cnt  out  32  number of updates with i_upd_mispredict=1.

## Operation
- Address split: index = pc[INDEX_W+1:2], tag = pc[ADDR_W-1:INDEX_W+2]. Bits [1:0] are ignored.
- Per entry: valid (reset to 0), tag, target, 2-bit counter (SNT=0, WNT=1, WT=2, ST=3). Only valid is reset; tag, target and counter are don't-care while invalid.
- Lookup is purely combinational from the current state. It never modifies state.
- Update with i_upd_valid=1 and i_flush=0:
  - Hit (valid and tag match): counter +1 if taken, saturating at ST; −1 if not taken, saturating at SNT. Target overwritten with i_upd_target when taken. Not-taken leaves the target unchanged.
  - Miss and taken: allocate (overwrite). Valid=1, tag, target written, counter=WT.
  - Miss and not-taken: no entry change.
  - o_upd_cnt +1. o_mispred_cnt +1 if i_upd_mispredict.
- i_flush=1: all valid bits cleared at the next edge. Any concurrent update to the entries is dropped, but the performance counters still count it.
- Performance counters wrap modulo 2^32 with no saturation.

## Timing
- Reset (async assert): all valid=0, both counters=0. Outputs immediately show o_pred_hit=0, o_pred_taken=0, o_pred_target=i_lookup_pc+4.
- Reset deassert needs no synchronisation inside the block.
- Lookup latency 0 cycles, combinational from i_lookup_pc and state.
- Update latency 1 cycle. A lookup of the same index in the update cycle sees pre-update state. A lookup on the following cycle sees the new state. There is no bypass.
- Flush takes effect at the posedge where i_flush=1. Lookups in that same cycle still see old entries.
- Aliasing: an update to a different tag at an occupied index follows the miss rules, so only a taken outcome evicts.
- Reset asserted mid-operation discards any in-flight update. No partial write occurs.

## Structure
- Package btb_pkg holds:
  - the counter typedef (2-bit enum SNT/WNT/WT/ST);
  - ALLOC_STATE = WT;
  - function sat_next(cnt, taken) returning the saturated next counter.
- Entry arrays are held in flops, not RAM, because reset and flush must clear valid in one cycle and lookup must be combinational.
- No sub-module is required. The counter update is the package function, and all arrays live in this module.

## Test plan
- Reset, then lookup 0x0000_0100 → hit=0, taken=0, target=0x0000_0104. Both perf counters read 0.
- Update pc=0x100 taken, target 0x200. Next cycle lookup 0x100 → hit=1, taken=1, target=0x200. In the update cycle itself the lookup still shows hit=0.
- Counter hysteresis at 0x100, starting from WT: one not-taken gives WNT (taken=0, hit=1). Two further taken updates give ST. Two not-taken give WNT (taken=0). A third not-taken gives SNT, and a fourth stays at SNT.
- Alias (INDEX_W=6): pc 0x100 allocated. Update pc 0x1100 not-taken → 0x100 entry unchanged. Update 0x1100 taken, target 0x300 → lookup 0x100 gives hit=0; lookup 0x1100 gives target 0x300.
- i_flush together with update of 0x400 taken → next cycle all lookups miss and 0x400 is not allocated. o_upd_cnt incremented by 1.
- Preload o_mispred_cnt to 0xFFFF_FFFF via 2^32−1 forced updates (or a bench force), then one mispredict update → count wraps to 0. Then assert i_rst_n low mid-cycle → outputs clear asynchronously.
